// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, register-address type and pipeline update modes
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int CTRL_W = 8;
  localparam int RA_W   = 4;

  typedef logic [RA_W-1:0] reg_addr_t;

  localparam reg_addr_t R0 = '0;

  // What the ID/EX register does on a given edge, highest priority first in the top.
  typedef enum logic [1:0] {
    UPD_LOAD   = 2'd0,
    UPD_BUBBLE = 2'd1,
    UPD_HOLD   = 2'd2,
    UPD_FLUSH  = 2'd3
  } upd_e;

  function automatic logic addr_hit(input logic we, input reg_addr_t dst, input reg_addr_t src);
    return we && (dst == src);
  endfunction

endpackage

// File: rtl/id_ex_pipe_if.sv
// rtl/id_ex_pipe_if.sv - decode/forwarding inputs and EX-stage outputs of the ID/EX register
interface id_ex_pipe_if #(
  parameter int DW = cpu_pkg::DATA_W,
  parameter int CW = cpu_pkg::CTRL_W
);
  import cpu_pkg::*;

  logic            id_vld;
  reg_addr_t       id_p0_addr;
  reg_addr_t       id_p1_addr;
  logic [DW-1:0]   id_p0;
  logic [DW-1:0]   id_p1;
  reg_addr_t       id_dst_addr;
  logic            id_we;
  logic            id_mem_rd;
  logic [CW-1:0]   id_ctrl;

  reg_addr_t       exm_dst_addr;
  logic            exm_we;
  logic [DW-1:0]   exm_data;
  reg_addr_t       wb_dst_addr;
  logic            wb_we;
  logic [DW-1:0]   wb_data;

  logic            ex_stall;
  logic            flush;

  logic            ex_vld;
  logic [DW-1:0]   ex_op0;
  logic [DW-1:0]   ex_op1;
  reg_addr_t       ex_dst_addr;
  logic            ex_we;
  logic            ex_mem_rd;
  logic [CW-1:0]   ex_ctrl;
  logic            id_stall;
  logic [15:0]     bubble_cnt;

  modport master (
    output id_vld, id_p0_addr, id_p1_addr, id_p0, id_p1, id_dst_addr, id_we, id_mem_rd, id_ctrl,
    output exm_dst_addr, exm_we, exm_data, wb_dst_addr, wb_we, wb_data, ex_stall, flush,
    input  ex_vld, ex_op0, ex_op1, ex_dst_addr, ex_we, ex_mem_rd, ex_ctrl, id_stall, bubble_cnt
  );

  modport slave (
    input  id_vld, id_p0_addr, id_p1_addr, id_p0, id_p1, id_dst_addr, id_we, id_mem_rd, id_ctrl,
    input  exm_dst_addr, exm_we, exm_data, wb_dst_addr, wb_we, wb_data, ex_stall, flush,
    output ex_vld, ex_op0, ex_op1, ex_dst_addr, ex_we, ex_mem_rd, ex_ctrl, id_stall, bubble_cnt
  );

endinterface

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - operand bypass: R0, then EX/MEM, then MEM/WB, then register-file data
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  reg_addr_t     src_addr,
  input  logic [DW-1:0] rf_data,
  input  reg_addr_t     exm_dst_addr,
  input  logic          exm_we,
  input  logic [DW-1:0] exm_data,
  input  reg_addr_t     wb_dst_addr,
  input  logic          wb_we,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] op
);

  always_comb begin
    op = rf_data;
    if (src_addr == R0)
      op = '0;
    else if (addr_hit(exm_we, exm_dst_addr, src_addr))
      op = exm_data;
    else if (addr_hit(wb_we, wb_dst_addr, src_addr))
      op = wb_data;
  end

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with operand forwarding, load-use bubbles and flush
module id_ex_pipe
  import cpu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int CW = CTRL_W
) (
  input logic         clk,
  input logic         rst,
  id_ex_pipe_if.slave bus
);

  reg_addr_t     src0_q;
  reg_addr_t     src1_q;
  upd_e          upd;
  logic          load_use;
  logic          hold;
  reg_addr_t     sel_addr0;
  reg_addr_t     sel_addr1;
  logic [DW-1:0] sel_data0;
  logic [DW-1:0] sel_data1;
  logic [DW-1:0] fwd0;
  logic [DW-1:0] fwd1;

  assign load_use = bus.ex_vld && bus.ex_mem_rd && (bus.ex_dst_addr != R0) && bus.id_vld &&
                    ((bus.ex_dst_addr == bus.id_p0_addr) || (bus.ex_dst_addr == bus.id_p1_addr));
  assign bus.id_stall = load_use;

  always_comb begin
    if (bus.flush)         upd = UPD_FLUSH;
    else if (bus.ex_stall) upd = UPD_HOLD;
    else if (load_use)     upd = UPD_BUBBLE;
    else                   upd = UPD_LOAD;
  end

  // While held, the same muxes re-forward into the parked operands using the stored sources.
  assign hold      = (upd == UPD_HOLD);
  assign sel_addr0 = hold ? src0_q     : bus.id_p0_addr;
  assign sel_addr1 = hold ? src1_q     : bus.id_p1_addr;
  assign sel_data0 = hold ? bus.ex_op0 : bus.id_p0;
  assign sel_data1 = hold ? bus.ex_op1 : bus.id_p1;

  fwd_mux #(.DW(DW)) u_fwd0 (
    .src_addr(sel_addr0), .rf_data(sel_data0),
    .exm_dst_addr(bus.exm_dst_addr), .exm_we(bus.exm_we), .exm_data(bus.exm_data),
    .wb_dst_addr(bus.wb_dst_addr), .wb_we(bus.wb_we), .wb_data(bus.wb_data),
    .op(fwd0)
  );

  fwd_mux #(.DW(DW)) u_fwd1 (
    .src_addr(sel_addr1), .rf_data(sel_data1),
    .exm_dst_addr(bus.exm_dst_addr), .exm_we(bus.exm_we), .exm_data(bus.exm_data),
    .wb_dst_addr(bus.wb_dst_addr), .wb_we(bus.wb_we), .wb_data(bus.wb_data),
    .op(fwd1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ex_vld      <= 1'b0;
      bus.ex_we       <= 1'b0;
      bus.ex_mem_rd   <= 1'b0;
      bus.ex_op0      <= '0;
      bus.ex_op1      <= '0;
      bus.ex_dst_addr <= R0;
      bus.ex_ctrl     <= '0;
      bus.bubble_cnt  <= '0;
      src0_q          <= R0;
      src1_q          <= R0;
    end else begin
      unique case (upd)
        UPD_FLUSH: begin
          bus.ex_vld    <= 1'b0;
          bus.ex_we     <= 1'b0;
          bus.ex_mem_rd <= 1'b0;
        end
        UPD_HOLD: begin
          bus.ex_op0 <= fwd0;
          bus.ex_op1 <= fwd1;
        end
        UPD_BUBBLE: begin
          bus.ex_vld    <= 1'b0;
          bus.ex_we     <= 1'b0;
          bus.ex_mem_rd <= 1'b0;
          if (bus.bubble_cnt != 16'hFFFF)
            bus.bubble_cnt <= bus.bubble_cnt + 16'd1;
        end
        UPD_LOAD: begin
          bus.ex_vld      <= bus.id_vld;
          bus.ex_we       <= bus.id_we && bus.id_vld && (bus.id_dst_addr != R0);
          bus.ex_mem_rd   <= bus.id_mem_rd && bus.id_vld;
          bus.ex_op0      <= fwd0;
          bus.ex_op1      <= fwd1;
          bus.ex_dst_addr <= bus.id_dst_addr;
          bus.ex_ctrl     <= bus.id_ctrl;
          src0_q          <= bus.id_p0_addr;
          src1_q          <= bus.id_p1_addr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - forwarding vectors, stall/flush/reset sequences and randomized model check
module tb_id_ex_pipe;
  import cpu_pkg::*;

  localparam int DW = 16;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_pipe_if #(.DW(DW), .CW(CW)) bus ();
  id_ex_pipe #(.DW(DW), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  a0, a1;
    logic [15:0] d0, d1;
    logic [3:0]  ed;
    logic        ew;
    logic [15:0] edat;
    logic [3:0]  wd;
    logic        ww;
    logic [15:0] wdat;
    logic [15:0] e0, e1;
  } vec_t;

  vec_t vt[6];

  // expected-state of the EX entry
  logic        m_vld, m_we, m_mrd;
  logic [15:0] m_op0, m_op1, m_bcnt;
  logic [3:0]  m_dst, m_s0, m_s1;
  logic [7:0]  m_ctrl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_vld = 0; bus.id_p0_addr = 0; bus.id_p1_addr = 0; bus.id_p0 = 0; bus.id_p1 = 0;
    bus.id_dst_addr = 0; bus.id_we = 0; bus.id_mem_rd = 0; bus.id_ctrl = 0;
    bus.exm_dst_addr = 0; bus.exm_we = 0; bus.exm_data = 0;
    bus.wb_dst_addr = 0; bus.wb_we = 0; bus.wb_data = 0;
    bus.ex_stall = 0; bus.flush = 0;
  endtask

  // Forwarding rule: R0 reads zero, youngest producer wins, else the register file value.
  function automatic logic [15:0] ref_fwd(input logic [3:0] src, input logic [15:0] rf);
    if (src == 0) return 16'h0;
    if (bus.exm_we && bus.exm_dst_addr == src) return bus.exm_data;
    if (bus.wb_we && bus.wb_dst_addr == src) return bus.wb_data;
    return rf;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".ex_vld"}, 32'(bus.ex_vld), 32'(m_vld));
    chk({tag, ".ex_we"}, 32'(bus.ex_we), 32'(m_we));
    chk({tag, ".ex_mem_rd"}, 32'(bus.ex_mem_rd), 32'(m_mrd));
    chk({tag, ".bubble_cnt"}, 32'(bus.bubble_cnt), 32'(m_bcnt));
    if (m_vld) begin
      chk({tag, ".ex_op0"}, 32'(bus.ex_op0), 32'(m_op0));
      chk({tag, ".ex_op1"}, 32'(bus.ex_op1), 32'(m_op1));
      chk({tag, ".ex_dst_addr"}, 32'(bus.ex_dst_addr), 32'(m_dst));
      chk({tag, ".ex_ctrl"}, 32'(bus.ex_ctrl), 32'(m_ctrl));
    end
  endtask

  initial begin
    logic exp_stall;

    vt[0] = '{4'd3, 4'd4, 16'h0000, 16'h4444, 4'd0, 1'b0, 16'h0000, 4'd3, 1'b1, 16'h1234, 16'h1234, 16'h4444};
    vt[1] = '{4'd3, 4'd0, 16'h1111, 16'h2222, 4'd3, 1'b1, 16'hAAAA, 4'd3, 1'b1, 16'h5555, 16'hAAAA, 16'h0000};
    vt[2] = '{4'd0, 4'd0, 16'hFFFF, 16'hFFFF, 4'd0, 1'b1, 16'hBBBB, 4'd0, 1'b1, 16'hCCCC, 16'h0000, 16'h0000};
    vt[3] = '{4'd7, 4'd7, 16'h0101, 16'h0202, 4'd7, 1'b0, 16'hAAAA, 4'd7, 1'b0, 16'h5555, 16'h0101, 16'h0202};
    vt[4] = '{4'd5, 4'd6, 16'h0001, 16'h0002, 4'd6, 1'b1, 16'h6666, 4'd5, 1'b1, 16'h5555, 16'h5555, 16'h6666};
    vt[5] = '{4'd9, 4'd10, 16'h9999, 16'hAAAA, 4'd8, 1'b1, 16'h7777, 4'd11, 1'b1, 16'h8888, 16'h9999, 16'hAAAA};

    idle();
    rst = 1'b1;
    #12;
    chk("reset.ex_vld", 32'(bus.ex_vld), 0);
    chk("reset.ex_op0", 32'(bus.ex_op0), 0);
    chk("reset.ex_ctrl", 32'(bus.ex_ctrl), 0);
    chk("reset.bubble_cnt", 32'(bus.bubble_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      bus.id_vld = 1; bus.id_dst_addr = 4'd1; bus.id_we = 1; bus.id_mem_rd = 0; bus.id_ctrl = 8'(i + 1);
      bus.id_p0_addr = vt[i].a0; bus.id_p1_addr = vt[i].a1; bus.id_p0 = vt[i].d0; bus.id_p1 = vt[i].d1;
      bus.exm_dst_addr = vt[i].ed; bus.exm_we = vt[i].ew; bus.exm_data = vt[i].edat;
      bus.wb_dst_addr = vt[i].wd; bus.wb_we = vt[i].ww; bus.wb_data = vt[i].wdat;
      tick();
      chk($sformatf("vec%0d.ex_op0", i), 32'(bus.ex_op0), 32'(vt[i].e0));
      chk($sformatf("vec%0d.ex_op1", i), 32'(bus.ex_op1), 32'(vt[i].e1));
      chk($sformatf("vec%0d.ex_vld", i), 32'(bus.ex_vld), 1);
      chk($sformatf("vec%0d.ex_ctrl", i), 32'(bus.ex_ctrl), 32'(i + 1));
    end

    // load to R5 followed by a reader of R5
    idle();
    bus.id_vld = 1; bus.id_we = 1; bus.id_mem_rd = 1; bus.id_dst_addr = 4'd5;
    tick();
    chk("lu.bubble_cnt0", 32'(bus.bubble_cnt), 0);
    bus.id_mem_rd = 0; bus.id_dst_addr = 4'd2; bus.id_p0_addr = 4'd5; bus.id_p1_addr = 4'd1;
    #1;
    chk("lu.id_stall", 32'(bus.id_stall), 1);
    tick();
    chk("lu.bubble_vld", 32'(bus.ex_vld), 0);
    chk("lu.bubble_we", 32'(bus.ex_we), 0);
    chk("lu.bubble_cnt1", 32'(bus.bubble_cnt), 1);
    chk("lu.id_stall_clear", 32'(bus.id_stall), 0);
    tick();
    chk("lu.reload_vld", 32'(bus.ex_vld), 1);
    chk("lu.reload_dst", 32'(bus.ex_dst_addr), 2);

    // three-cycle hold with a writeback to R2 in the middle
    idle();
    bus.id_vld = 1; bus.id_we = 1; bus.id_dst_addr = 4'd4; bus.id_ctrl = 8'h5A;
    bus.id_p0_addr = 4'd2; bus.id_p1_addr = 4'd3; bus.id_p0 = 16'h0002; bus.id_p1 = 16'h0003;
    tick();
    chk("hold.pre_op0", 32'(bus.ex_op0), 32'h0002);
    bus.ex_stall = 1; bus.id_p0_addr = 4'd9; bus.id_p0 = 16'hDEAD; bus.id_dst_addr = 4'd7; bus.id_ctrl = 8'h00;
    tick();
    bus.wb_we = 1; bus.wb_dst_addr = 4'd2; bus.wb_data = 16'hBEEF;
    tick();
    bus.wb_we = 0;
    tick();
    chk("hold.op0", 32'(bus.ex_op0), 32'hBEEF);
    chk("hold.op1", 32'(bus.ex_op1), 32'h0003);
    chk("hold.dst", 32'(bus.ex_dst_addr), 4);
    chk("hold.ctrl", 32'(bus.ex_ctrl), 32'h5A);
    chk("hold.vld", 32'(bus.ex_vld), 1);
    chk("hold.we", 32'(bus.ex_we), 1);

    // flush wins over stall
    bus.flush = 1;
    tick();
    chk("flush.vld", 32'(bus.ex_vld), 0);
    chk("flush.we", 32'(bus.ex_we), 0);
    bus.flush = 0; bus.ex_stall = 0;
    tick();
    chk("flush.reload", 32'(bus.ex_vld), 1);

    // asynchronous reset between edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("areset.ex_vld", 32'(bus.ex_vld), 0);
    chk("areset.ex_op0", 32'(bus.ex_op0), 0);
    chk("areset.ex_dst", 32'(bus.ex_dst_addr), 0);
    chk("areset.bubble_cnt", 32'(bus.bubble_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    tick();

    m_vld = 0; m_we = 0; m_mrd = 0; m_op0 = 0; m_op1 = 0; m_bcnt = 0;
    m_dst = 0; m_s0 = 0; m_s1 = 0; m_ctrl = 0;
    check_outputs("rnd_start");

    for (int n = 0; n < 400; n++) begin
      bus.id_vld = 1'($urandom_range(0, 3) != 0);
      bus.id_p0_addr = 4'($urandom_range(0, 5)); bus.id_p1_addr = 4'($urandom_range(0, 5));
      bus.id_p0 = 16'($urandom); bus.id_p1 = 16'($urandom);
      bus.id_dst_addr = 4'($urandom_range(0, 5)); bus.id_we = 1'($urandom);
      bus.id_mem_rd = 1'($urandom); bus.id_ctrl = 8'($urandom);
      bus.exm_dst_addr = 4'($urandom_range(0, 5)); bus.exm_we = 1'($urandom); bus.exm_data = 16'($urandom);
      bus.wb_dst_addr = 4'($urandom_range(0, 5)); bus.wb_we = 1'($urandom); bus.wb_data = 16'($urandom);
      bus.ex_stall = 1'($urandom_range(0, 4) == 0);
      bus.flush = 1'($urandom_range(0, 9) == 0);
      #1;
      exp_stall = m_vld && m_mrd && (m_dst != 0) && bus.id_vld &&
                  ((m_dst == bus.id_p0_addr) || (m_dst == bus.id_p1_addr));
      chk("rnd.id_stall", 32'(bus.id_stall), 32'(exp_stall));
      if (bus.flush) begin
        m_vld = 0; m_we = 0; m_mrd = 0;
      end else if (bus.ex_stall) begin
        m_op0 = ref_fwd(m_s0, m_op0);
        m_op1 = ref_fwd(m_s1, m_op1);
      end else if (exp_stall) begin
        m_vld = 0; m_we = 0; m_mrd = 0;
        if (m_bcnt != 16'hFFFF) m_bcnt = m_bcnt + 1;
      end else begin
        m_vld = bus.id_vld;
        m_we = bus.id_we && bus.id_vld && (bus.id_dst_addr != 0);
        m_mrd = bus.id_mem_rd && bus.id_vld;
        m_op0 = ref_fwd(bus.id_p0_addr, bus.id_p0);
        m_op1 = ref_fwd(bus.id_p1_addr, bus.id_p1);
        m_dst = bus.id_dst_addr; m_ctrl = bus.id_ctrl;
        m_s0 = bus.id_p0_addr; m_s1 = bus.id_p1_addr;
      end
      tick();
      check_outputs($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter DW, default 16, datapath width.
REQ-002 SHALL have parameter CW, default 8, opaque control bundle width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports id_vld input 1, id_p0_addr/id_p1_addr input 4, id_p0/id_p1 input DW: decode-stage valid, source addresses, register-file read data.
REQ-006 SHALL have ports id_dst_addr input 4, id_we input 1, id_mem_rd input 1, id_ctrl input CW: decode destination, write enable, load flag, control bundle.
REQ-007 SHALL have ports exm_dst_addr input 4, exm_we input 1, exm_data input DW: EX/MEM forwarding source.
REQ-008 SHALL have ports wb_dst_addr input 4, wb_we input 1, wb_data input DW: MEM/WB forwarding source (same bus as register-file write port).
REQ-009 SHALL have ports ex_stall input 1 (downstream hold) and flush input 1 (branch kill).
REQ-010 SHALL have outputs ex_vld 1, ex_op0/ex_op1 DW, ex_dst_addr 4, ex_we 1, ex_mem_rd 1, ex_ctrl CW: registered EX-stage entry.
REQ-011 SHALL have outputs id_stall 1 (combinational load-use stall to fetch/decode) and bubble_cnt 16 (registered).

Function
REQ-012 Operand select per source SHALL be: address 0 -> 0; exm_we & exm_dst_addr match -> exm_data; else wb_we & wb_dst_addr match -> wb_data; else id_pN.
REQ-013 id_stall SHALL be 1 iff ex_vld & ex_mem_rd & ex_dst_addr!=0 & id_vld & (ex_dst_addr==id_p0_addr | ex_dst_addr==id_p1_addr), independent of ex_stall.
REQ-014 Per-edge update priority SHALL be: flush > ex_stall > id_stall > normal load.
REQ-015 flush SHALL clear ex_vld, ex_we, ex_mem_rd next edge, even with ex_stall=1.
REQ-016 ex_stall=1 (no flush) SHALL hold all outputs, except held operands SHALL be refreshed per REQ-012 priority (exm, then wb) against internally stored source addresses.
REQ-017 id_stall=1 (no flush/stall) SHALL load a bubble: ex_vld=0, ex_we=0, ex_mem_rd=0, data fields don't-care.
REQ-018 Normal load SHALL capture id_* with forwarded operands; ex_vld=id_vld; ex_we=id_we&id_vld; ex_mem_rd=id_mem_rd&id_vld.
REQ-019 Latency SHALL be exactly one cycle from id_* to ex_*.
REQ-020 bubble_cnt SHALL increment on each edge where REQ-017 applies, saturating at 16'hFFFF, never wrapping.
REQ-021 ex_we SHALL be forced 0 whenever ex_dst_addr==0.

Reset
REQ-022 rst SHALL asynchronously clear ex_vld, ex_we, ex_mem_rd, ex_op0, ex_op1, ex_dst_addr, ex_ctrl, stored source addresses, bubble_cnt to 0.
REQ-023 rst asserted mid-stall or mid-flush SHALL override all; first edge after deassertion SHALL behave per REQ-014.

Structure
REQ-024 DW, register-address width 4, CW, and R0 constant SHALL live in shared package cpu_pkg.
REQ-025 Operand selection SHALL be sub-module fwd_mux, instantiated twice.

Verification
REQ-026 wb writes R3=16'h1234 while id reads p0=R3 with stale id_p0=16'h0000 -> ex_op0=16'h1234 next cycle.
REQ-027 exm R3=16'hAAAA and wb R3=16'h5555 same cycle, id reads R3 -> ex_op0=16'hAAAA; id reads R0 with exm_dst_addr=0 -> ex_op0=0.
REQ-028 ex holds load to R5, id reads R5 -> id_stall=1, one bubble, bubble_cnt 0->1; next cycle id_stall=0.
REQ-029 ex_stall=1 for 3 cycles with entry source R2, wb writes R2=16'hBEEF during cycle 2 -> ex_op* from R2 = 16'hBEEF after hold, other outputs unchanged.
REQ-030 flush with ex_stall=1 -> ex_vld=0 next edge; rst mid-operation -> all outputs 0 immediately, without clock edge.
